fir_sample_feeder: RTL and testbench
====================================

Name: fir_sample_feeder

Overview:
- Upstream stage of the 64-tap DA FIR core.
- Accepts 16-bit signed samples on a valid/ready stream and buffers them in a small internal FIFO.
- Writes them into the core's input FIFO as 64-word frames, one word per clock, throttled by the core's able2write.
- Enforces a programmable idle gap between frames so the core can finish its accumulation pass before the next frame starts.

Parameters:
- DATA_W, 16, sample width (two's complement).
- BUF_DEPTH, 8, internal skid FIFO depth; power of 2, minimum 2.
- FRAME_LEN, 64, words per frame written to the core.
- GAP_CYCLES, 40, idle clk1 cycles after each frame's last write; minimum 1.

Ports:
- clk1  in  1  system clock; write-side clock of the core.
- rstn  in  1  reset, active-low.
- s_data  in  DATA_W  upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  feeder can accept a sample this cycle.
- core_able2write  in  1  core can accept writes (the core's able2write_out).
- data_out  out  DATA_W  sample to the core's data_in.
- write_ctrl  out  1  write strobe to the core's in_write_ctrlX.
- frame_done  out  1  one-cycle pulse, coincident with the cycle after the last write of a frame.
- frame_count  out  16  number of completed frames; wraps at 2^16.
- underrun_cycles  out  16  BURST cycles stalled on an empty buffer; saturates at 16'hFFFF.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset:
  - One clock, clk1; reset is asynchronous and active-low (rstn).
  - All state clears on rstn low.
- Reset values:
  - s_ready=0 while rstn low, and 1 from the first clock after release.
  - data_out=0, write_ctrl=0, frame_done=0, frame_count=0, underrun_cycles=0, busy=0.
  - Buffer empty, state IDLE, word_cnt=0, gap_cnt=0.
- Internal buffer:
  - Synchronous FIFO, BUF_DEPTH entries, occupancy counter of width log2(BUF_DEPTH)+1.
  - s_ready = !full (registered-free, derived from occupancy).
  - Push when s_valid && s_ready.
  - Pop when the FSM issues a write.
  - Push and pop in the same cycle: occupancy unchanged, data order preserved.
  - A push to a full buffer is impossible because s_ready is low; s_data is ignored.
- Write issue (registered outputs, latency one cycle):
  - A pop at edge N drives data_out=popped word and write_ctrl=1 for the cycle after edge N.
  - With no pop, write_ctrl=0 and data_out holds its last value.
- FSM states IDLE, BURST, GAP:
  - IDLE:
    - If buffer non-empty and core_able2write=1: pop, issue write, word_cnt=1, go to BURST.
    - If FRAME_LEN=1, go directly to GAP instead.
  - BURST, each cycle:
    - If core_able2write=1 and buffer non-empty: pop, issue write, word_cnt+1.
    - If core_able2write=0: no pop, write_ctrl=0, counters hold.
    - If core_able2write=1 and buffer empty: no pop, underrun_cycles+1 (saturating).
    - The write that makes word_cnt reach FRAME_LEN is the frame's last write. On the same edge: word_cnt clears to 0, gap_cnt loads GAP_CYCLES, frame_count increments, and the state goes to GAP.
  - GAP:
    - No pops, write_ctrl=0, gap_cnt decrements each cycle.
    - On the edge where gap_cnt reaches 0, go to IDLE.
    - The buffer keeps accepting samples throughout GAP.
  - frame_done:
    - Asserted for exactly the first cycle in GAP, alongside write_ctrl=1 for the last word.
- Boundary conditions:
  - A frame is never split across GAP; stalls inside BURST extend the frame, they do not abort it.
  - core_able2write dropping mid-frame pauses the burst; writes resume the first cycle it returns high.
  - rstn asserted mid-frame discards the partial frame and buffer contents. The core is reset by the same rstn.
  - frame_count wraps from 16'hFFFF to 0.
  - Back-to-back frames: minimum spacing between the last write of frame k and the first write of frame k+1 is GAP_CYCLES+1 cycles.

Test Plan:
- Reset: hold rstn low 3 cycles with s_valid=1 → s_ready=0, write_ctrl=0, all outputs 0; s_ready=1 on the first clock after release.
- Continuous stream: s_valid=1, s_data=1,2,...,64, core_able2write=1 → 64 consecutive write_ctrl=1 cycles, data_out=1..64 in order; frame_done single pulse; frame_count=1; next write exactly 41 cycles after the last.
- Backpressure: drop core_able2write for cycles 10–19 of the burst → write_ctrl=0 for those cycles, no data lost; frame still exactly 64 words, data_out sequence contiguous.
- Underrun: supply s_valid only every 3rd cycle → writes spaced accordingly; underrun_cycles = BURST cycles with an empty buffer (126 for a 64-word frame); frame_count=1.
- Buffer full: core_able2write=0 and s_valid=1 for 12 cycles → s_ready falls after 8 accepted samples; samples 1–8 are emitted first once core_able2write=1.
- Reset mid-frame: assert rstn at word 30 → state IDLE, buffer empty, frame_count unchanged (0), next frame starts from freshly pushed data.

Source files
------------

// File: rtl/fir_sample_feeder.sv
// Sample feeder for the 64-tap DA FIR core: buffers an upstream valid/ready stream
// and writes it to the core as fixed-length frames separated by an idle gap.
module fir_sample_feeder #(
  parameter int DATA_W     = 16,
  parameter int BUF_DEPTH  = 8,
  parameter int FRAME_LEN  = 64,
  parameter int GAP_CYCLES = 40
) (
  input  logic              clk1,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              core_able2write,
  output logic [DATA_W-1:0] data_out,
  output logic              write_ctrl,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [15:0]       underrun_cycles,
  output logic              busy
);
  localparam int AW  = $clog2(BUF_DEPTH);
  localparam int WCW = $clog2(FRAME_LEN + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ;
  logic              rdy_en;
  logic              full, empty, push, pop, last, stall_empty;
  logic [WCW-1:0]    word_cnt;
  logic [GCW-1:0]    gap_cnt;

  assign full    = (occ == (AW+1)'(BUF_DEPTH));
  assign empty   = (occ == '0);
  // rdy_en keeps s_ready low through reset and until the first edge after release
  assign s_ready = rdy_en && !full;
  assign push    = s_valid && s_ready;

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  always_ff @(posedge clk1) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, BURST: if (pop) state_nx = last ? GAP : BURST;
      GAP:         if (gap_cnt == GCW'(1)) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  // word_cnt is 0 in IDLE, so FRAME_LEN==1 makes the very first pop the last one
  always_comb begin
    pop         = (state != GAP) && !empty && core_able2write;
    last        = (word_cnt == WCW'(FRAME_LEN - 1));
    stall_empty = (state == BURST) && core_able2write && empty;
    busy        = (state != IDLE);
  end

  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      word_cnt        <= '0;
      gap_cnt         <= '0;
      frame_count     <= '0;
      underrun_cycles <= '0;
      data_out        <= '0;
      write_ctrl      <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      write_ctrl <= pop;
      frame_done <= pop && last;
      if (pop) begin
        data_out <= mem[rd_ptr];
        word_cnt <= last ? '0 : word_cnt + 1'b1;
      end
      if (pop && last) begin
        gap_cnt     <= GCW'(GAP_CYCLES);
        frame_count <= frame_count + 1'b1;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      if (stall_empty && underrun_cycles != 16'hFFFF)
        underrun_cycles <= underrun_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: reset, streaming, backpressure, underrun,
// buffer full and mid-frame reset, checked against hand-computed expectations.
module tb_fir_sample_feeder;
  logic        clk1 = 1'b0;
  logic        rstn;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        core_able2write;
  logic [15:0] data_out;
  logic        write_ctrl;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [15:0] underrun_cycles;
  logic        busy;

  fir_sample_feeder dut (
    .clk1(clk1), .rstn(rstn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_able2write(core_able2write), .data_out(data_out), .write_ctrl(write_ctrl),
    .frame_done(frame_done), .frame_count(frame_count),
    .underrun_cycles(underrun_cycles), .busy(busy)
  );

  always #5 clk1 = ~clk1;

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  // write log sampled on the falling edge
  int          wr_cyc[$];
  logic [15:0] wr_dat[$];
  int          fd_cyc[$];
  always @(negedge clk1) begin
    if (write_ctrl) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(data_out);
    end
    if (frame_done) fd_cyc.push_back(cyc);
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_reset();
    @(posedge clk1); #1;
    rstn = 1'b0; s_valid = 1'b0; core_able2write = 1'b0;
    repeat (2) @(posedge clk1);
    #1 rstn = 1'b1;
    @(posedge clk1); #1;
  endtask

  task automatic push_seq(input int first, input int n);
    int k, guard;
    logic acc;
    k = 0; guard = 0;
    s_valid = 1'b1; s_data = 16'(first);
    while (k < n && guard < 5000) begin
      @(negedge clk1); acc = s_ready;
      @(posedge clk1); #1;
      guard++;
      if (acc) begin k++; s_data = 16'(first + k); end
    end
    s_valid = 1'b0;
    chk("push_done", k, n);
  endtask

  task automatic wait_writes(input int n);
    int guard;
    guard = 0;
    while (wr_cyc.size() < n && guard < 5000) begin
      @(posedge clk1); guard++;
    end
    chk("wait_writes", wr_cyc.size() >= n, 1);
  endtask

  initial begin
    int base, fdb, k, guard, bad;
    logic acc;

    // reset with upstream asserting valid
    rstn = 1'b0; s_valid = 1'b1; s_data = 16'h1234; core_able2write = 1'b1;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_write_ctrl", write_ctrl, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_underrun", underrun_cycles, 0);
    chk("rst_busy", busy, 0);
    s_valid = 1'b0; rstn = 1'b1;
    #1 chk("rdy_before_clk", s_ready, 0);
    @(posedge clk1); #1;
    chk("rdy_after_clk", s_ready, 1);

    // continuous stream, next frame spacing
    base = wr_cyc.size(); fdb = fd_cyc.size();
    core_able2write = 1'b1;
    push_seq(1, 70);
    wait_writes(base + 65);
    bad = 0;
    for (int i = 0; i < 65; i++) if (wr_dat[base+i] !== 16'(i + 1)) bad++;
    chk("cont_data_order", bad, 0);
    chk("cont_span", wr_cyc[base+63] - wr_cyc[base], 63);
    chk("cont_next_gap", wr_cyc[base+64] - wr_cyc[base+63], 41);
    chk("cont_fd_count", fd_cyc.size() - fdb, 1);
    chk("cont_fd_cycle", fd_cyc[fdb], wr_cyc[base+63]);
    chk("cont_frame_count", frame_count, 1);
    chk("cont_underrun", underrun_cycles, 0);

    // backpressure for 10 cycles after the 10th write
    do_reset();
    base = wr_cyc.size();
    core_able2write = 1'b1;
    fork
      push_seq(101, 64);
      begin
        guard = 0;
        while (wr_cyc.size() < base + 10 && guard < 2000) begin
          @(negedge clk1); #1; guard++;
        end
        core_able2write = 1'b0;
        repeat (10) @(posedge clk1);
        #1 core_able2write = 1'b1;
      end
    join
    wait_writes(base + 64);
    repeat (45) @(posedge clk1);
    bad = 0;
    for (int i = 0; i < 64; i++) if (wr_dat[base+i] !== 16'(101 + i)) bad++;
    chk("bp_data_order", bad, 0);
    chk("bp_stall_gap", wr_cyc[base+10] - wr_cyc[base+9], 11);
    chk("bp_span", wr_cyc[base+63] - wr_cyc[base], 73);
    chk("bp_frame_words", wr_cyc.size() - base, 64);
    chk("bp_frame_count", frame_count, 1);

    // underrun: one sample every third cycle
    do_reset();
    base = wr_cyc.size();
    core_able2write = 1'b1;
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 16'(i + 1);
      @(posedge clk1); #1;
      s_valid = 1'b0;
      repeat (2) @(posedge clk1);
      #1;
    end
    wait_writes(base + 64);
    repeat (3) @(posedge clk1);
    chk("ur_underrun", underrun_cycles, 126);
    chk("ur_frame_count", frame_count, 1);
    chk("ur_span", wr_cyc[base+63] - wr_cyc[base], 189);
    chk("ur_last_data", wr_dat[base+63], 64);

    // buffer full while core is blocked
    do_reset();
    base = wr_cyc.size();
    core_able2write = 1'b0;
    s_valid = 1'b1; k = 0;
    for (int i = 0; i < 12; i++) begin
      s_data = 16'(k + 1);
      @(negedge clk1); acc = s_ready;
      @(posedge clk1); #1;
      if (acc) k++;
    end
    s_valid = 1'b0;
    chk("full_accepted", k, 8);
    chk("full_s_ready", s_ready, 0);
    chk("full_no_writes", wr_cyc.size() - base, 0);
    core_able2write = 1'b1;
    wait_writes(base + 8);
    repeat (4) @(posedge clk1);
    bad = 0;
    for (int i = 0; i < 8; i++) if (wr_dat[base+i] !== 16'(i + 1)) bad++;
    chk("full_drain_order", bad, 0);
    chk("full_drain_count", wr_cyc.size() - base, 8);
    chk("full_burst_busy", busy, 1);

    // reset at word 30 of a frame
    do_reset();
    base = wr_cyc.size();
    core_able2write = 1'b1;
    s_valid = 1'b1; k = 0; guard = 0;
    while (wr_cyc.size() < base + 30 && guard < 2000) begin
      s_data = 16'(k + 1);
      @(negedge clk1); acc = s_ready;
      @(posedge clk1); #1;
      guard++;
      if (acc) k++;
    end
    rstn = 1'b0; s_valid = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_frame_count", frame_count, 0);
    chk("mid_rst_write_ctrl", write_ctrl, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    repeat (2) @(posedge clk1);
    #1 rstn = 1'b1;
    @(posedge clk1); #1;
    base = wr_cyc.size();
    push_seq(201, 64);
    wait_writes(base + 64);
    repeat (2) @(posedge clk1);
    chk("mid_first_data", wr_dat[base], 201);
    chk("mid_last_data", wr_dat[base+63], 264);
    chk("mid_frame_count", frame_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
